pipe_control_unit: RTL

//  Control unit directly upstream of the 5-stage 16-bit pipeline datapath. Decodes the decode-stage

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/hazard_detect.sv | 38 +++
 rtl/pipe_control_unit.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit pipeline control path: opcodes, ALU function codes,
// sequencing states and instruction field offsets.
package cpu_pkg;

   localparam int INSTW   = 16;
   localparam int OP_LSB  = 12;
   localparam int RD_LSB  = 8;
   localparam int RS1_LSB = 4;
   localparam int RS2_LSB = 0;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_ADDI = 4'h5;
   localparam logic [3:0] OP_LD   = 4'h6;
   localparam logic [3:0] OP_ST   = 4'h7;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check: flags when the load now in execute writes a register the decode-stage
// instruction reads. Purely combinational; r0 is an ordinary register here.
module hazard_detect
   import cpu_pkg::*;
#(
   parameter int RAW = 4
) (
   input  logic             ldE,
   input  logic [RAW-1:0]   destE,
   input  logic [INSTW-1:0] instD,
   output logic             hazard
);

   logic [3:0]     w_op;
   logic [RAW-1:0] w_rd;
   logic [RAW-1:0] w_rs1;
   logic [RAW-1:0] w_rs2;
   logic           w_match;

   assign w_op  = instD[OP_LSB +: 4];
   assign w_rd  = instD[RD_LSB +: RAW];
   assign w_rs1 = instD[RS1_LSB +: RAW];
   assign w_rs2 = instD[RS2_LSB +: RAW];

   // Stores read rd as the data operand, so rd counts as a source for ST only.
   always_comb begin
      w_match = 1'b0;
      case (w_op)
         OP_ADD, OP_SUB, OP_AND, OP_OR: w_match = (w_rs1 == destE) || (w_rs2 == destE);
         OP_ADDI, OP_LD:                w_match = (w_rs1 == destE);
         OP_ST:                         w_match = (w_rs1 == destE) || (w_rd == destE);
         default:                       w_match = 1'b0;
      endcase
   end

   assign hazard = ldE && w_match;

endmodule

// File: rtl/pipe_control_unit.sv
// Decode-stage control unit: combinational control bundle from instD plus the RUN/STALL/FLUSH/HALT
// sequencer that owns PC enable, load-use bubbles, post-jump flush and halt.
module pipe_control_unit
   import cpu_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int OPW          = 4,
   parameter int RAW          = 4,
   parameter int CNTW         = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [INSTW-1:0] instD,
   output logic             enable,
   output logic             branchC,
   output logic             flushC,
   output logic             RegWriteC,
   output logic             MemWriteC,
   output logic             MemToRegC,
   output logic             immediateC,
   output logic [1:0]       alufuncC,
   output logic             halted,
   output logic             illegal,
   output logic [CNTW-1:0]  stall_count
);

   localparam logic [2:0] FLUSH_LOAD = FLUSH_CYCLES[2:0];

   state_t          r_state;
   logic            r_ldE;
   logic [RAW-1:0]  r_destE;
   logic [2:0]      r_flush_cnt;
   logic [CNTW-1:0] r_stall_cnt;

   logic [OPW-1:0]  w_op;
   logic [RAW-1:0]  w_rd;
   logic            w_hazard;

   // Raw decode of instD, before sequencing decides whether it is actually issued.
   logic            w_d_rw, w_d_mw, w_d_m2r, w_d_imm, w_d_jmp, w_d_halt, w_d_ill;
   logic [1:0]      w_d_alu;

   logic            w_en, w_br, w_fl, w_rw, w_mw, w_m2r, w_imm, w_ill;
   logic [1:0]      w_alu;

   assign w_op = instD[OP_LSB +: OPW];
   assign w_rd = instD[RD_LSB +: RAW];

   hazard_detect #(.RAW(RAW)) u_hazard (
      .ldE    (r_ldE),
      .destE  (r_destE),
      .instD  (instD),
      .hazard (w_hazard)
   );

   always_comb begin
      w_d_rw   = 1'b0;
      w_d_mw   = 1'b0;
      w_d_m2r  = 1'b0;
      w_d_imm  = 1'b0;
      w_d_alu  = ALU_ADD;
      w_d_jmp  = 1'b0;
      w_d_halt = 1'b0;
      w_d_ill  = 1'b0;
      case (w_op)
         OP_NOP:  ;
         OP_ADD:  begin w_d_rw = 1'b1; w_d_alu = ALU_ADD; end
         OP_SUB:  begin w_d_rw = 1'b1; w_d_alu = ALU_SUB; end
         OP_AND:  begin w_d_rw = 1'b1; w_d_alu = ALU_AND; end
         OP_OR:   begin w_d_rw = 1'b1; w_d_alu = ALU_OR;  end
         OP_ADDI: begin w_d_rw = 1'b1; w_d_imm = 1'b1; end
         OP_LD:   begin w_d_rw = 1'b1; w_d_m2r = 1'b1; w_d_imm = 1'b1; end
         OP_ST:   begin w_d_mw = 1'b1; w_d_imm = 1'b1; end
         OP_JMP:  w_d_jmp  = 1'b1;
         OP_HALT: w_d_halt = 1'b1;
         default: w_d_ill  = 1'b1;
      endcase
   end

   // Issue selection; anything not explicitly issued is a bubble with every C output low.
   always_comb begin
      w_en  = 1'b0;
      w_br  = 1'b0;
      w_fl  = 1'b0;
      w_rw  = 1'b0;
      w_mw  = 1'b0;
      w_m2r = 1'b0;
      w_imm = 1'b0;
      w_alu = 2'b00;
      w_ill = 1'b0;
      case (r_state)
         ST_RUN: begin
            if (w_hazard || w_d_halt) begin
               w_en = 1'b0;
            end else if (w_d_jmp) begin
               w_en = 1'b1;
               w_br = 1'b1;
            end else if (w_d_ill) begin
               w_en  = 1'b1;
               w_ill = 1'b1;
            end else begin
               w_en  = 1'b1;
               w_rw  = w_d_rw;
               w_mw  = w_d_mw;
               w_m2r = w_d_m2r;
               w_imm = w_d_imm;
               w_alu = w_d_alu;
            end
         end
         ST_FLUSH: begin
            w_en = 1'b1;
            w_fl = 1'b1;
         end
         default: w_en = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_RUN;
         r_ldE       <= 1'b0;
         r_destE     <= '0;
         r_flush_cnt <= 3'd0;
         r_stall_cnt <= '0;
      end else begin
         r_ldE   <= 1'b0;
         r_destE <= '0;
         case (r_state)
            ST_RUN: begin
               if (w_hazard) begin
                  r_state <= ST_STALL;
                  if (r_stall_cnt != {CNTW{1'b1}})
                     r_stall_cnt <= r_stall_cnt + 1'b1;
               end else if (w_d_jmp) begin
                  r_state     <= ST_FLUSH;
                  r_flush_cnt <= FLUSH_LOAD;
               end else if (w_d_halt) begin
                  r_state <= ST_HALT;
               end else if (!w_d_ill) begin
                  r_ldE   <= w_d_m2r;
                  r_destE <= w_d_rw ? w_rd : '0;
               end
            end
            ST_STALL: r_state <= ST_RUN;
            ST_FLUSH: begin
               r_flush_cnt <= r_flush_cnt - 3'd1;
               if (r_flush_cnt <= 3'd1)
                  r_state <= ST_RUN;
            end
            default: r_state <= ST_HALT;
         endcase
      end
   end

   // Outputs are gated by the asynchronous reset so they drop the instant reset asserts.
   assign enable      = reset && w_en;
   assign branchC     = reset && w_br;
   assign flushC      = reset && w_fl;
   assign RegWriteC   = reset && w_rw;
   assign MemWriteC   = reset && w_mw;
   assign MemToRegC   = reset && w_m2r;
   assign immediateC  = reset && w_imm;
   assign alufuncC    = reset ? w_alu : 2'b00;
   assign illegal     = reset && w_ill;
   assign halted      = reset && (r_state == ST_HALT);
   assign stall_count = r_stall_cnt;

endmodule
